// File: rtl/seven_segment_capture_if.sv
// Scan-line and decoded-result bundle between a seven-segment source and the capture block.
interface seven_segment_capture_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        err_clr;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        decode_err;
    logic        active;

    modport master (
        output seg, an, err_clr,
        input  value, blank, frame_valid, decode_err, active
    );

    modport slave (
        input  seg, an, err_clr,
        output value, blank, frame_valid, decode_err, active
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Samples multiplexed seven-segment scan lines and rebuilds the four displayed hex digits,
// with glitch filtering, pattern decode, frame assembly and an idle timeout.
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_segment_capture_if.slave  bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMR_W = 20;
    localparam int unsigned PAT_W = 11;

    logic [6:0]       seg_s1, seg_s2;
    logic [3:0]       an_s1, an_s2;
    logic [1:0]       fill;
    logic             prev_vld;
    logic [PAT_W-1:0] prev_pat;
    logic [CNT_W-1:0] stab_cnt;
    logic [TMR_W-1:0] idle_tmr;
    logic [3:0]       seen;
    logic [15:0]      slot_val;
    logic [3:0]       slot_blank;
    logic [15:0]      value_q;
    logic [3:0]       blank_q;
    logic             frame_valid_q;
    logic             decode_err_q;
    logic             active_q;

    logic             pat_same_c;
    logic             capture_c;
    logic [3:0]       an_norm_c;
    logic [6:0]       seg_norm_c;
    logic [3:0]       nib_c;
    logic             seg_blank_c;
    logic             seg_bad_c;
    logic [1:0]       idx_c;
    logic [3:0]       sel_c;
    logic             an_none_c;
    logic             an_onehot_c;
    logic             valid_cap_c;
    logic             err_set_c;
    logic             frame_done_c;
    logic [15:0]      slot_val_next_c;
    logic [3:0]       slot_blank_next_c;

    assign bus.value       = value_q;
    assign bus.blank       = blank_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.decode_err  = decode_err_q;
    assign bus.active      = active_q;

    // Two-flop synchronizers; fill/prev_vld keep the reset contents from looking like a held pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            an_s1    <= '0;
            an_s2    <= '0;
            fill     <= '0;
            prev_vld <= 1'b0;
            prev_pat <= '0;
        end else begin
            seg_s1   <= bus.seg[6:0];
            seg_s2   <= seg_s1;
            an_s1    <= bus.an;
            an_s2    <= an_s1;
            fill     <= {fill[0], 1'b1};
            prev_vld <= fill[1];
            prev_pat <= {an_s2, seg_s2};
        end
    end

    assign pat_same_c  = prev_vld && ({an_s2, seg_s2} == prev_pat);
    assign capture_c   = pat_same_c && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign an_norm_c   = AN_ACTIVE_LOW  ? ~an_s2  : an_s2;
    assign seg_norm_c  = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
    assign an_none_c   = (an_norm_c == 4'b0000);
    assign an_onehot_c = $onehot(an_norm_c);

    // Stability counter saturates so a held pattern captures only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (!pat_same_c) begin
            stab_cnt <= '0;
        end else if (stab_cnt < CNT_W'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    // abcdefg pattern back to a nibble
    always_comb begin
        nib_c       = 4'h0;
        seg_blank_c = 1'b0;
        seg_bad_c   = 1'b0;
        case (seg_norm_c)
            7'b1111110: nib_c = 4'h0;
            7'b0110000: nib_c = 4'h1;
            7'b1101101: nib_c = 4'h2;
            7'b1111001: nib_c = 4'h3;
            7'b0110011: nib_c = 4'h4;
            7'b1011011: nib_c = 4'h5;
            7'b1011111: nib_c = 4'h6;
            7'b1110000: nib_c = 4'h7;
            7'b1111111: nib_c = 4'h8;
            7'b1111011: nib_c = 4'h9;
            7'b1110111: nib_c = 4'hA;
            7'b0011111: nib_c = 4'hB;
            7'b1001110: nib_c = 4'hC;
            7'b0111101: nib_c = 4'hD;
            7'b1001111: nib_c = 4'hE;
            7'b1000111: nib_c = 4'hF;
            7'b0000000: seg_blank_c = 1'b1;
            default:    seg_bad_c   = 1'b1;
        endcase
    end

    always_comb begin
        idx_c = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_norm_c[i]) idx_c = 2'(i);
        end
    end

    assign sel_c        = 4'b0001 << idx_c;
    assign valid_cap_c  = capture_c && an_onehot_c;
    assign err_set_c    = capture_c && !an_none_c && (!an_onehot_c || seg_bad_c);
    assign frame_done_c = valid_cap_c && ((seen | sel_c) == 4'b1111);

    always_comb begin
        slot_val_next_c             = slot_val;
        slot_blank_next_c           = slot_blank;
        slot_val_next_c[idx_c*4 +: 4] = nib_c;
        slot_blank_next_c[idx_c]    = seg_blank_c;
    end

    // Frame assembly, idle timeout and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tmr      <= '0;
            seen          <= '0;
            slot_val      <= '0;
            slot_blank    <= '0;
            value_q       <= '0;
            blank_q       <= 4'b1111;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;

            if (capture_c) begin
                idle_tmr <= '0;
            end else if (idle_tmr != TMR_W'(TIMEOUT_CYCLES)) begin
                idle_tmr <= idle_tmr + TMR_W'(1);
                if (idle_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    active_q <= 1'b0;
                    seen     <= '0;
                end
            end

            if (valid_cap_c) begin
                active_q   <= 1'b1;
                slot_val   <= slot_val_next_c;
                slot_blank <= slot_blank_next_c;
                if (frame_done_c) begin
                    value_q       <= slot_val_next_c;
                    blank_q       <= slot_blank_next_c;
                    frame_valid_q <= 1'b1;
                    seen          <= '0;
                end else begin
                    seen <= seen | sel_c;
                end
            end

            if (err_set_c) begin
                decode_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                decode_err_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side counterpart of the multiplexed seven-segment display driver. Samples the external `seg`/`an` scan lines (from a display driver or a board under test) and reconstructs the four displayed hex digits as a 16-bit value. It filters scan glitches and decodes segment patterns back to nibbles. A frame-complete pulse is issued once every digit position has been refreshed. Used as a loop-back checker for the display path and as a decoder for external seven-segment boards.

## Interface
- `STABLE_CYCLES`, 4: synchronized `{an,seg}` must hold unchanged this many cycles before capture (range 1–255).
- `TIMEOUT_CYCLES`, 65535: cycles without any capture before `active` drops (range 1–2^20-1).
- `AN_ACTIVE_LOW`, 1: 1 means an anode line at 0 selects its digit.
- `SEG_ACTIVE_LOW`, 0: 1 means a segment line at 0 is lit.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `seg`  in  8  segment lines (asynchronous): `seg[6:0]`=a..g with a=`seg[6]`, `seg[7]`=dp (ignored).
- `an`  in  4  anode lines (asynchronous); `an[i]` selects digit i.
- `err_clr`  in  1  single-cycle pulse that clears `decode_err`.
- `value`  out  16  last complete frame; digit i is at `value[4i+3:4i]`.
- `blank`  out  4  bit i set when digit i was dark in the last frame.
- `frame_valid`  out  1  one-cycle pulse when `value`/`blank` update.
- `decode_err`  out  1  sticky; set on an illegal pattern.
- `active`  out  1  high while captures occur within `TIMEOUT_CYCLES`.

## Operation
- **Input path:** `seg[6:0]` and `an` each pass through a 2-flop synchronizer, then are normalized to active-high using the polarity parameters.
- **Stability counter:**
  - Resets to 0 whenever the synchronized 11-bit `{an,seg}` differs from the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
  - A capture event fires exactly once, on the cycle the counter reaches `STABLE_CYCLES-1` with the pattern unchanged. No re-capture occurs until the pattern changes.
- **Anode handling at capture:**
  - Exactly one-hot: digit index i = position of the set bit.
  - All zero: event ignored (inter-digit blanking); no error.
  - Two or more bits set: event ignored, `decode_err` set.
- **Segment decode (abcdefg):**
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - 0000000 is a blank: nibble 0, blank flag 1.
  - Any other pattern: nibble 0, blank flag 0, and `decode_err` set.
- **Frame assembly:**
  - Each valid capture writes the nibble and blank flag into working slot i and sets `seen[i]`.
  - When the write makes `seen`=1111, on the same edge: `value` takes all four slots (including the new one), `blank` likewise, `frame_valid`=1, and `seen` clears.
  - Rewriting an already-seen slot overwrites it and does not advance the frame.
- **Error flag:** `err_clr` clears `decode_err`. If a set condition and `err_clr` occur in the same cycle, set wins.
- **Idle timer:**
  - Reloads to 0 on every capture event (including ignored and error events).
  - Otherwise increments.
  - On reaching `TIMEOUT_CYCLES`: `active`=0 and `seen` clears, so a partial frame is discarded. The timer holds there.
  - `active`=1 again on the next valid one-hot capture.

## Timing
- **Reset values:** `value`=0, `blank`=4'b1111, `frame_valid`=0, `decode_err`=0, `active`=0. Synchronizers, counters and `seen` all clear.
- **Reset mid-frame:** discards the partial frame. The synchronizers refill, so the first capture comes no earlier than 2+`STABLE_CYCLES` cycles after deassert.
- **Capture latency:** an input held constant from edge t is written to its working slot at edge t+2+`STABLE_CYCLES`.
- **Frame output:** `frame_valid` and `value` change on that same edge; `frame_valid` is high for exactly one cycle.
- **Glitch rejection:** a pattern lasting fewer than `STABLE_CYCLES` synchronized cycles is never captured.
- **Minimum frame time:** the scan must hold each digit for at least `STABLE_CYCLES`+2 cycles.
- **Back-to-back frames:** permitted; `frame_valid` may pulse every 4 capture events.

## Test plan
- **Normal scan:** digits 3,2,1,0 show patterns for 1,2,3,4, each held 16 cycles, active-low anodes. Expect exactly one `frame_valid`, `value`=16'h1234, `blank`=0000, `decode_err`=0.
- **Glitch:** a 2-cycle glitch of `an`=4'b0000 pattern 1111111 inserted mid-scan. Expect no capture from it and `value` unchanged.
- **Illegal pattern:** digit 0 shows 1010101. Expect `decode_err`=1 and, at frame end, nibble 0 and `blank[0]`=0. Then pulse `err_clr` together with a second illegal pattern: `decode_err` stays 1. Pulse `err_clr` alone: `decode_err` goes 0.
- **Invalid anodes:** `an` with two bits selected, held stable. Expect `decode_err`=1 and `seen` unchanged. `an` with none selected: no error.
- **Timeout:** `TIMEOUT_CYCLES`=100; stop scanning after 3 digits. Expect `active` to fall at the 100th idle cycle. A following full scan yields a frame built only from new captures.
- **Mid-frame reset:** assert `rst_n` low mid-frame. Expect all outputs at reset values, and no `frame_valid` until 4 new captures complete after release.
